// File: rtl/fa_serial_seq.sv
// Bit-serial add sequencer: streams two W-bit operands LSB-first through an external
// single-bit full adder and gathers the sum bits and final carry into registers.
module fa_serial_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum_out,
  output logic         cout,
  output logic         fa_ai,
  output logic         fa_bi,
  output logic         fa_ci,
  input  logic         fa_so,
  input  logic         fa_co
);

  localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic [W-1:0]     s_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     s_next;

  // The sum bit returned by fa this cycle enters at the MSB so the LSB ends up at bit 0.
  assign s_next = {fa_so, s_sh[W-1:1]};

  always_comb begin
    fa_ai = 1'b0;
    fa_bi = 1'b0;
    fa_ci = 1'b0;
    if (state == SHIFT) begin
      fa_ai = a_sh[0];
      fa_bi = b_sh[0];
      fa_ci = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_next;
          carry <= fa_co;
          // Counter holds at its last value rather than wrapping on the final bit.
          if (cnt == CNT_LAST) begin
            sum_out <= s_next;
            cout    <= fa_co;
            state   <= DONE;
            done    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_serial_seq.sv
// Bench for fa_serial_seq: wraps it with a behavioural full adder and checks every cycle
// against an operation-level reference model, plus directed literal scenarios.
module tb_fa_serial_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout;
  logic         fa_ai;
  logic         fa_bi;
  logic         fa_ci;
  logic         fa_so;
  logic         fa_co;

  always #5 clk = ~clk;

  assign fa_so = fa_ai ^ fa_bi ^ fa_ci;
  assign fa_co = (fa_ai & fa_bi) | (fa_ai & fa_ci) | (fa_bi & fa_ci);

  fa_serial_seq #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout),
    .fa_ai   (fa_ai),
    .fa_bi   (fa_bi),
    .fa_ci   (fa_ci),
    .fa_so   (fa_so),
    .fa_co   (fa_co)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Carry entering bit i of a+b+c is bit i of the sum of the operands' low i bits.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input int i);
    logic [31:0] m;
    logic [31:0] s;
    m = (32'd1 << i) - 32'd1;
    s = (32'(a) & m) + (32'(b) & m) + 32'(c);
    return s[i];
  endfunction

  // Reference model: ph 0 = idle, 1..W = bit cycles, W+1 = result cycle.
  int           ph = 0;
  logic [W-1:0] ma = '0;
  logic [W-1:0] mb = '0;
  logic         mc = 1'b0;
  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0;
  logic         model_en = 1'b0;
  int           cyc = 0;
  int           n_done = 0;
  int           acc_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      ph       <= 0;
      exp_sum  <= '0;
      exp_cout <= 1'b0;
      model_en <= 1'b1;
    end else if (ph == 0) begin
      if (start) begin
        ma <= a_in;
        mb <= b_in;
        mc <= cin;
        ph <= 1;
        acc_q.push_back(cyc);
      end
    end else if (ph == W) begin
      ph <= W + 1;
      {exp_cout, exp_sum} <= (W+1)'(ma) + (W+1)'(mb) + (W+1)'(mc);
    end else if (ph == W + 1) begin
      ph     <= 0;
      n_done <= n_done + 1;
    end else begin
      ph <= ph + 1;
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      logic sh;
      sh = (ph >= 1) && (ph <= W);
      check("busy", 32'(busy), 32'(ph != 0));
      check("done", 32'(done), 32'(ph == W + 1));
      check("sum_out", 32'(sum_out), 32'(exp_sum));
      check("cout", 32'(cout), 32'(exp_cout));
      check("fa_ai", 32'(fa_ai), sh ? 32'(ma[ph-1]) : 32'd0);
      check("fa_bi", 32'(fa_bi), sh ? 32'(mb[ph-1]) : 32'd0);
      check("fa_ci", 32'(fa_ci), sh ? 32'(carry_into(ma, mb, mc, ph - 1)) : 32'd0);
    end
  end

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output int lat, output int busy_cyc, output int ci_cyc);
    wait_idle();
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
    lat = 0; busy_cyc = 0; ci_cyc = 0;
    while (!done && lat < 50) begin
      if (busy) busy_cyc++;
      if (fa_ci) ci_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy) busy_cyc++;
  endtask

  initial begin
    int lat, bc, cc, dcount, base, guard;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_fa_ci", 32'(fa_ci), 32'd0);
    rst = 1'b0;

    run_op(8'h05, 8'h03, 1'b0, lat, bc, cc);
    check("t1_latency_edges", 32'(lat), 32'd8);
    check("t1_sum", 32'(sum_out), 32'h08);
    check("t1_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    check("t1_busy_after_done", 32'(busy), 32'd0);

    run_op(8'hFF, 8'h01, 1'b0, lat, bc, cc);
    check("t2_sum", 32'(sum_out), 32'h00);
    check("t2_cout", 32'(cout), 32'd1);
    check("t2_busy_cycles", 32'(bc), 32'd9);

    run_op(8'hFF, 8'hFF, 1'b1, lat, bc, cc);
    check("t3_sum", 32'(sum_out), 32'hFF);
    check("t3_cout", 32'(cout), 32'd1);
    check("t3_fa_ci_cycles", 32'(cc), 32'd8);

    // Reset in the fourth bit cycle of an add.
    wait_idle();
    a_in = 8'h55; b_in = 8'h33; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_sum", 32'(sum_out), 32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    dcount = 0;
    repeat (12) begin
      if (done) dcount++;
      @(posedge clk); #1;
    end
    check("t5_no_done", 32'(dcount), 32'd0);
    run_op(8'h10, 8'h20, 1'b0, lat, bc, cc);
    check("t5_sum_after", 32'(sum_out), 32'h30);
    check("t5_cout_after", 32'(cout), 32'd0);

    // Start held high: accepts must be exactly W+2 cycles apart.
    wait_idle();
    acc_q.delete();
    start = 1'b1;
    repeat (45) begin
      a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_idle();
    check("t4_accept_count", 32'(acc_q.size()), 32'd5);
    for (int i = 1; i < acc_q.size(); i++)
      check("t4_accept_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'(W + 2));

    // Random traffic with occasional resets.
    base = n_done;
    guard = 0;
    while ((n_done - base) < 1000 && guard < 30000) begin
      start = ($urandom_range(3) != 0);
      a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
      rst = ($urandom_range(399) == 0);
      @(posedge clk); #1;
      guard++;
    end
    rst = 1'b0; start = 1'b0;
    check("t6_ops_completed", 32'((n_done - base) >= 1000), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
